// File: rtl/if_fetch_align.sv
// RV32IC fetch front end: streams words from a 1-cycle-latency imem into a halfword
// queue and realigns them into 16-bit and 32-bit instructions for decode.
module if_fetch_align #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_dout,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_compressed
);

    // Six halfwords packed as one vector; q[0] lives in bits [15:0].
    logic [31:0]           fpc_r;
    logic                  inflight_r;
    logic                  drop_lo_r;
    logic [95:0]           q_r;
    logic [2:0]            count_r;
    logic [31:0]           head_pc_r;
    logic [ADDR_WIDTH-1:0] imem_addr_r;

    logic [15:0] q0_s;
    logic [15:0] q1_s;
    logic        head_comp_s;
    logic        valid_s;
    logic        fire_s;
    logic [1:0]  pop_n_s;
    logic [1:0]  push_n_s;
    logic [95:0] push_vec_s;
    logic [2:0]  base_s;
    logic [95:0] q_sh_s;
    logic [95:0] keep_s;
    logic [95:0] q_nxt_s;
    logic [2:0]  count_nxt_s;
    logic        issue_s;
    logic [31:0] fpc_inc_s;

    // Head decode: instruction length, availability and pop size.
    always_comb begin
        q0_s        = q_r[15:0];
        q1_s        = q_r[31:16];
        head_comp_s = (q0_s[1:0] != 2'b11);
        if (head_comp_s) begin
            valid_s = (count_r >= 3'd1);
        end else begin
            valid_s = (count_r >= 3'd2);
        end
        fire_s = valid_s & instr_ready;
        if (fire_s) begin
            pop_n_s = head_comp_s ? 2'd1 : 2'd2;
        end else begin
            pop_n_s = 2'd0;
        end
    end

    // Decode-facing outputs, forced to zero while nothing valid is at the head.
    always_comb begin
        instr_valid      = valid_s;
        instr_pc         = head_pc_r;
        instr            = 32'h0000_0000;
        instr_compressed = 1'b0;
        if (valid_s) begin
            instr_compressed = head_comp_s;
            instr            = head_comp_s ? {16'h0000, q0_s} : {q1_s, q0_s};
        end else begin
            instr_compressed = 1'b0;
            instr            = 32'h0000_0000;
        end
    end

    // Next queue contents: drop popped halfwords, then append the arriving word behind them.
    always_comb begin
        push_n_s   = 2'd0;
        push_vec_s = 96'h0;
        if (inflight_r) begin
            if (drop_lo_r) begin
                push_n_s   = 2'd1;
                push_vec_s = {80'h0, imem_dout[31:16]};
            end else begin
                push_n_s   = 2'd2;
                push_vec_s = {64'h0, imem_dout};
            end
        end else begin
            push_n_s   = 2'd0;
            push_vec_s = 96'h0;
        end
        base_s      = count_r - {1'b0, pop_n_s};
        q_sh_s      = q_r >> {pop_n_s, 4'b0000};
        keep_s      = (96'd1 << {base_s, 4'b0000}) - 96'd1;
        q_nxt_s     = (q_sh_s & keep_s) | (push_vec_s << {base_s, 4'b0000});
        count_nxt_s = base_s + {1'b0, push_n_s};
        // An in-flight word reserves two slots so the queue can never exceed six.
        issue_s     = (({1'b0, count_r} + {2'b00, inflight_r, 1'b0}) <= 4'd4) && !redirect_valid;
        fpc_inc_s   = fpc_r + 32'd4;
    end

    // State update: reset dominates redirect, redirect dominates normal push/pop/issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_r       <= RESET_PC;
            inflight_r  <= 1'b0;
            drop_lo_r   <= 1'b0;
            q_r         <= 96'h0;
            count_r     <= 3'd0;
            head_pc_r   <= RESET_PC;
            imem_addr_r <= RESET_PC[ADDR_WIDTH+1:2];
        end else if (redirect_valid) begin
            fpc_r       <= redirect_pc & 32'hFFFF_FFFC;
            inflight_r  <= 1'b0;
            drop_lo_r   <= redirect_pc[1];
            q_r         <= q_r;
            count_r     <= 3'd0;
            head_pc_r   <= redirect_pc & 32'hFFFF_FFFE;
            imem_addr_r <= redirect_pc[ADDR_WIDTH+1:2];
        end else begin
            q_r       <= q_nxt_s;
            count_r   <= count_nxt_s;
            head_pc_r <= head_pc_r + {29'd0, pop_n_s, 1'b0};
            if (inflight_r) begin
                drop_lo_r <= 1'b0;
            end else begin
                drop_lo_r <= drop_lo_r;
            end
            if (issue_s) begin
                inflight_r  <= 1'b1;
                fpc_r       <= fpc_inc_s;
                imem_addr_r <= fpc_inc_s[ADDR_WIDTH+1:2];
            end else begin
                inflight_r  <= 1'b0;
                fpc_r       <= fpc_r;
                imem_addr_r <= imem_addr_r;
            end
        end
    end

    assign imem_addr = imem_addr_r;

endmodule

// File: doc/if_fetch_align.md
Name: if_fetch_align

Overview:
Instruction-fetch front end that drives the synchronous instruction memory and turns its word stream into a stream of RV32IC instructions.
- Issues word addresses to the 1-cycle-latency instruction memory and captures the returned 32-bit words.
- Buffers words as halfwords and realigns them into 16-bit compressed or 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Delivers each instruction with its PC over a valid/ready handshake to decode.
- Accepts branch/jump redirects.

Parameters:
ADDR_WIDTH, 9, imem word-address width; fetch space is 2^ADDR_WIDTH words.
DATA_WIDTH, 32, imem word width; fixed at 32.
RESET_PC, 32'h0, byte PC after reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_addr  out  ADDR_WIDTH  word address to imem; imem samples it at each clk edge
imem_dout  in  DATA_WIDTH  imem read data, valid the cycle after the address was sampled
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  byte target; bit 0 ignored, bit 1 selects upper halfword
instr_valid  out  1  instr/instr_pc/instr_compressed valid
instr_ready  in  1  decode accepts when valid&ready
instr  out  32  instruction; compressed placed in [15:0], [31:16]=0
instr_pc  out  32  byte PC of instr
instr_compressed  out  1  instr[1:0]!=2'b11

Behaviour:
- State registers:
  - fpc: next fetch byte PC, word aligned.
  - inflight: a request was issued last cycle.
  - drop_lo: discard the low halfword of the arriving word.
  - Halfword queue q[0..5] with count 0..6.
  - head_pc: PC of q[0].
- Reset (rst_n=0 at edge):
  - fpc=RESET_PC, inflight=0, drop_lo=0, count=0, head_pc=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=RESET_PC, instr_compressed=0.
  - imem_addr=RESET_PC[ADDR_WIDTH+1:2].
  - Reset mid-operation discards the queue and any in-flight word; the next word to arrive is ignored.
- imem_addr is a register equal to fpc[ADDR_WIDTH+1:2].
- Issue rule: issue when count+2*inflight <= 4 and no redirect this cycle.
  - Issue means inflight<=1 next cycle and fpc<=fpc+4.
  - Otherwise inflight<=0 and fpc holds; imem_addr then re-reads the same word, which is ignored.
- Response: when inflight=1, imem_dout is pushed at the edge.
  - Low halfword first, then high halfword.
  - If drop_lo=1, only the high halfword is pushed, then drop_lo<=0.
- Decode of head:
  - q[0][1:0]!=2'b11 and count>=1: compressed, length 1 halfword.
  - q[0][1:0]==2'b11 and count>=2: 32-bit = {q[1],q[0]}.
  - q[0][1:0]==2'b11 and count==1: instr_valid=0; wait for next word.
- Outputs are combinational from the queue head: instr_valid, instr, instr_pc=head_pc, instr_compressed.
- Pop: valid&ready pops 1 or 2 halfwords and head_pc += 2 or 4, mod 2^32.
  - Push and pop in the same cycle are both applied.
  - count never exceeds 6.
- Latency: reset released at edge E0.
  - imem samples RESET_PC word at E1.
  - Word pushed at E2.
  - instr_valid=1 after E2.
- Throughput: sustains one 32-bit or one 16-bit instruction per cycle while instr_ready=1.
- Redirect (redirect_valid=1 at edge):
  - count<=0, head_pc<=redirect_pc & ~1, fpc<=redirect_pc & ~3, inflight<=0.
  - drop_lo<=redirect_pc[1].
  - The in-flight word is discarded and no pop occurs.
  - The next cycle issues the target word.
  - instr_valid is 0 until the target word arrives (two cycles).
- Simultaneous events:
  - Redirect with valid&ready: the instruction counts as accepted by decode, but queue state follows the redirect.
  - Reset overrides redirect.
- Wrap-around:
  - fpc increments mod 2^32 and imem_addr wraps at 2^ADDR_WIDTH words.
  - A 32-bit instruction at the last halfword of memory combines with word 0.
- instr, instr_pc and instr_compressed are don't-care when instr_valid=0; a bench must not check them then.

Test Plan:
1. Reset, RESET_PC=0, imem word0=32'h00500093, instr_ready=1 -> instr_valid first high 2 cycles after reset release; instr=32'h00500093, instr_pc=0, instr_compressed=0.
2. word0={16'h4505,16'h4501}, word1=32'h00a00113 -> instr 32'h00004501 @pc0, then 32'h00004505 @pc2, then 32'h00a00113 @pc4, on consecutive cycles.
3. Straddle: word0={16'h0093,16'h4501}, word1={16'h4601,16'h0050} -> 32'h00004501 @0, 32'h00500093 @2 (compressed=0), 32'h00004601 @6.
4. instr_ready=0 for 10 cycles after first valid -> instr stable at same PC; count saturates at 6 with no overflow; issue stops; resume yields sequential PCs with none lost or duplicated.
5. redirect_valid with redirect_pc=32'h0000_0016 while a word is in flight -> stale word discarded; first valid instr_pc=32'h16 taken from the high half of word 5, 2 cycles later.
6. Assert rst_n=0 for one cycle mid-stream with instr_valid=1 -> next cycle instr_valid=0; fetch restarts at RESET_PC with the same latency as scenario 1.
